tap_delay_line: RTL and testbench

Parametrised tapped delay line for the adaptive-filter datapath. It holds the last TAPS input samples and exposes all taps in parallel on a flat bus. It tracks how many valid samples have been loaded since reset or clear. It also has a serial scan port that streams the taps one per cycle, newest first, to a shared multiply-accumulate unit. Shifting is blocked while a scan is in progress, so every scan reads one consistent snapshot of the taps.

---
 rtl/tap_delay_line.sv | 65 ++++++
 tb/tb_tap_delay_line.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tap_delay_line.sv
// tap_delay_line: tapped delay line with parallel taps, fill tracking and a snapshot-consistent serial scan port
module tap_delay_line #(
  parameter int WIDTH = 14,
  parameter int TAPS  = 16,
  localparam int CW = $clog2(TAPS + 1),
  localparam int IW = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WIDTH-1:0]      in,
  input  logic                  shift_en,
  output logic                  shift_rdy,
  input  logic                  clear,
  output logic [WIDTH*TAPS-1:0] taps,
  output logic [CW-1:0]         fill_cnt,
  output logic                  full,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_valid,
  output logic [WIDTH-1:0]      scan_data,
  output logic [IW-1:0]         scan_idx,
  output logic                  scan_last
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [WIDTH-1:0] tap_q [TAPS];
  logic [IW-1:0] next_idx;
  assign next_idx  = scan_idx + IW'(1);
  assign shift_rdy = (state == IDLE) && !scan_start && !clear;
  assign scan_busy = state == SCAN;
  assign scan_last = scan_valid && scan_idx == IW'(TAPS - 1);
  for (genvar i = 0; i < TAPS; i++) begin : g_taps
    assign taps[i*WIDTH +: WIDTH] = tap_q[i];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || clear) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
      fill_cnt   <= '0;
      full       <= 1'b0;
      state      <= IDLE;
      scan_valid <= 1'b0;
      scan_idx   <= '0;
      scan_data  <= '0;
    end else if (state == IDLE) begin
      if (scan_start) begin
        state      <= SCAN;
        scan_idx   <= '0;
        scan_data  <= tap_q[0];
        scan_valid <= 1'b1;
      end else if (shift_en) begin
        tap_q[0] <= in;
        for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
        fill_cnt <= (fill_cnt == CW'(TAPS)) ? fill_cnt : fill_cnt + CW'(1);
        full     <= fill_cnt >= CW'(TAPS - 1);
      end
    end else if (scan_idx == IW'(TAPS - 1)) begin
      state      <= IDLE;
      scan_valid <= 1'b0;
      scan_idx   <= '0;
    end else begin
      scan_idx  <= next_idx;
      scan_data <= tap_q[next_idx];
    end
  end
endmodule

// File: tb/tb_tap_delay_line.sv
// tb_tap_delay_line: randomized and directed checks of tap_delay_line against a queue-based reference model
module tb_tap_delay_line;
  localparam int W = 14, T = 16, CW = $clog2(T + 1), IW = $clog2(T);
  logic clk = 0, rstn = 0, shift_en = 0, clear = 0, scan_start = 0;
  logic [W-1:0] din = '0;
  logic shift_rdy, full, scan_busy, scan_valid, scan_last;
  logic [W*T-1:0] taps;
  logic [CW-1:0] fill_cnt;
  logic [W-1:0] scan_data;
  logic [IW-1:0] scan_idx;
  int checks = 0, errors = 0;
  int mq[$];
  int mfill, mpos, msidx, msdata;
  bit mscan, msv;

  tap_delay_line #(.WIDTH(W), .TAPS(T)) dut (
    .clk(clk), .rstn(rstn), .in(din), .shift_en(shift_en), .shift_rdy(shift_rdy),
    .clear(clear), .taps(taps), .fill_cnt(fill_cnt), .full(full),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_data(scan_data), .scan_idx(scan_idx), .scan_last(scan_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mq = {};
    repeat (T) mq.push_back(0);
    mfill = 0; mscan = 0; mpos = 0; msv = 0; msidx = 0; msdata = 0;
  endtask

  task automatic check_all();
    for (int k = 0; k < T; k++) chk($sformatf("tap%0d", k), taps[k*W +: W], mq[k]);
    chk("fill_cnt", fill_cnt, mfill);
    chk("full", full, mfill == T);
    chk("scan_busy", scan_busy, mscan);
    chk("scan_valid", scan_valid, msv);
    chk("scan_idx", scan_idx, msidx);
    chk("scan_data", scan_data, msdata);
    chk("scan_last", scan_last, msv && msidx == T - 1);
  endtask

  // Applies one clock of the behavioural rules to the model, then compares.
  task automatic step();
    #1;
    chk("shift_rdy", shift_rdy, !mscan && !scan_start && !clear);
    if (clear) begin
      mq = {}; repeat (T) mq.push_back(0);
      mfill = 0; mscan = 0; msv = 0; msidx = 0; msdata = 0;
    end else if (!mscan && scan_start) begin
      mscan = 1; mpos = 0; msv = 1; msidx = 0; msdata = mq[0];
    end else if (!mscan && shift_en) begin
      mq.push_front(int'(din));
      void'(mq.pop_back());
      mfill = (mfill < T) ? mfill + 1 : T;
    end else if (mscan) begin
      if (mpos == T - 1) begin
        mscan = 0; msv = 0; msidx = 0;
      end else begin
        mpos++; msidx = mpos; msdata = mq[mpos];
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1;
    // fill and overflow
    for (int i = 1; i <= 20; i++) begin
      shift_en = 1; din = W'(i);
      step();
    end
    chk("fill_tap0", taps[0 +: W], 20);
    chk("fill_tap15", taps[15*W +: W], 5);
    chk("fill_full", full, 1);
    // scan with shift held high throughout
    din = 14'h3FFF; scan_start = 1;
    step();
    scan_start = 0;
    for (int i = 1; i < T; i++) begin
      step();
      chk("scan_seq", scan_data, 20 - i);
    end
    step();
    chk("scan_end_valid", scan_valid, 0);
    step();
    chk("post_scan_tap0", taps[0 +: W], 14'h3FFF);
    // simultaneous scan_start and shift_en in IDLE
    shift_en = 1; scan_start = 1; din = W'($urandom);
    step();
    scan_start = 0; shift_en = 0;
    repeat (T + 1) step();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 49) == 0);
      scan_start = ($urandom_range(0, 9) == 0);
      shift_en = $urandom_range(0, 1);
      din = W'($urandom);
      step();
    end
    clear = 0; scan_start = 0; shift_en = 0;
    repeat (T + 1) step();
    // clear mid-scan at scan_idx 7
    shift_en = 1;
    repeat (5) begin din = W'($urandom); step(); end
    shift_en = 0; scan_start = 1;
    step();
    scan_start = 0;
    repeat (7) step();
    chk("pre_clear_idx", scan_idx, 7);
    clear = 1;
    step();
    clear = 0;
    chk("clear_valid", scan_valid, 0);
    chk("clear_fill", fill_cnt, 0);
    // async reset mid-scan
    shift_en = 1;
    repeat (6) begin din = W'($urandom); step(); end
    shift_en = 0; scan_start = 1;
    step();
    scan_start = 0;
    repeat (4) step();
    #2 rstn = 0;
    #1;
    mreset();
    check_all();
    @(posedge clk);
    #2 rstn = 1;
    #1;
    chk("rst_shift_rdy", shift_rdy, 1);
    shift_en = 1; din = W'($urandom);
    step();
    chk("rst_first_fill", fill_cnt, 1);
    shift_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
